// File: rtl/audio_mix_pkg.sv
// Shared types and sizing helpers for the multi-channel fading audio mixer.
// Holds the per-channel fade state encoding, the mix accumulator width and the unity gain.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        PLAY     = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_e;

    // Accumulator must hold NUM_CH full-scale products without overflow.
    function automatic int sum_width(input int sample_w, input int gain_w, input int num_ch);
        return sample_w + gain_w + 32'sd1 + $clog2(num_ch);
    endfunction

    function automatic int gain_unity(input int gain_w);
        return int'(32'd1 << gain_w);
    endfunction

endpackage

// File: rtl/audio_ch_fader.sv
// One channel's fade FSM and gain register; the gain ramps by RAMP_STEP per accepted frame.
// mute forces IDLE with zero gain on any cycle and overrides the enable request.
module audio_ch_fader
    import audio_mix_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_mute,
    input  logic              i_valid,
    output logic [GAIN_W:0]   o_gain,
    output logic              o_active
);

    localparam int UNITY_I = gain_unity(GAIN_W);
    // A step larger than unity behaves like a unity step and keeps the ramp sum in range.
    localparam logic [GAIN_W+1:0] STEP_V  = (GAIN_W+2)'((RAMP_STEP > UNITY_I) ? UNITY_I : RAMP_STEP);
    localparam logic [GAIN_W+1:0] UNITY_W = (GAIN_W+2)'(UNITY_I);
    localparam logic [GAIN_W:0]   UNITY_G = (GAIN_W+1)'(UNITY_I);
    localparam logic [GAIN_W:0]   ZERO_G  = {(GAIN_W+1){1'b0}};

    fade_state_e       r_state;
    logic [GAIN_W:0]   r_gain;
    logic              r_active;
    logic [GAIN_W+1:0] w_up_sum;
    logic [GAIN_W+1:0] w_dn_diff;
    logic [GAIN_W:0]   w_gain_up;
    logic [GAIN_W:0]   w_gain_dn;

    assign w_up_sum  = {1'b0, r_gain} + STEP_V;
    assign w_gain_up = (w_up_sum >= UNITY_W) ? UNITY_G : w_up_sum[GAIN_W:0];
    assign w_dn_diff = {1'b0, r_gain} - STEP_V;
    assign w_gain_dn = ({1'b0, r_gain} <= STEP_V) ? ZERO_G : w_dn_diff[GAIN_W:0];

    // Fade FSM: state, gain and active flag all move together on accepted frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_gain   <= ZERO_G;
            r_active <= 1'b0;
        end else if (i_mute) begin
            r_state  <= IDLE;
            r_gain   <= ZERO_G;
            r_active <= 1'b0;
        end else if (i_valid) begin
            case (r_state)
                IDLE: begin
                    if (i_en) begin
                        r_state  <= FADE_IN;
                        r_gain   <= w_gain_up;
                        r_active <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (!i_en) begin
                        r_gain   <= w_gain_dn;
                        r_state  <= (w_gain_dn == ZERO_G) ? IDLE : FADE_OUT;
                        r_active <= (w_gain_dn != ZERO_G);
                    end else begin
                        r_gain  <= w_gain_up;
                        r_state <= (w_gain_up == UNITY_G) ? PLAY : FADE_IN;
                    end
                end
                PLAY: begin
                    if (!i_en) begin
                        r_gain   <= w_gain_dn;
                        r_state  <= (w_gain_dn == ZERO_G) ? IDLE : FADE_OUT;
                        r_active <= (w_gain_dn != ZERO_G);
                    end
                end
                FADE_OUT: begin
                    if (i_en) begin
                        r_gain  <= w_gain_up;
                        r_state <= (w_gain_up == UNITY_G) ? PLAY : FADE_IN;
                    end else begin
                        r_gain   <= w_gain_dn;
                        r_state  <= (w_gain_dn == ZERO_G) ? IDLE : FADE_OUT;
                        r_active <= (w_gain_dn != ZERO_G);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_gain   <= ZERO_G;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_gain   = r_gain;
    assign o_active = r_active;

endmodule

// File: rtl/audio_fade_mixer.sv
// NUM_CH-channel fading mixer: per-channel gain ramps, product stage, sum/shift stage (latency 2).
// Define AUDIO_MIX_SATURATE_EN to clamp the mix and pulse clip; otherwise the mix wraps.
module audio_fade_mixer
    import audio_mix_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic                       mute,
    input  logic                       in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    output logic [SAMPLE_W-1:0]        out_sample,
    output logic [NUM_CH-1:0]          ch_active,
    output logic                       clip
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int SUM_W  = sum_width(SAMPLE_W, GAIN_W, NUM_CH);

    logic [GAIN_W:0]          w_gain [NUM_CH];
    logic signed [PROD_W-1:0] w_prod [NUM_CH];
    logic signed [PROD_W-1:0] r_prod [NUM_CH];
    logic                     r_v1;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  w_shift;
    logic [SAMPLE_W-1:0]      w_res;
    logic                     w_clip;
    logic                     r_out_valid;
    logic [SAMPLE_W-1:0]      r_out_sample;
    logic                     r_clip;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [PROD_W-1:0] w_s_ext;
        logic signed [PROD_W-1:0] w_g_ext;

        audio_ch_fader #(
            .GAIN_W    (GAIN_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_fader (
            .i_clk    (CLOCK_50),
            .i_rst_n  (resetn),
            .i_en     (ch_enable[k]),
            .i_mute   (mute),
            .i_valid  (in_valid),
            .o_gain   (w_gain[k]),
            .o_active (ch_active[k])
        );

        // Gain is unsigned, so it is zero-extended before the signed multiply.
        assign w_s_ext   = {{(GAIN_W+1){in_sample[k*SAMPLE_W+SAMPLE_W-1]}}, in_sample[k*SAMPLE_W +: SAMPLE_W]};
        assign w_g_ext   = {{SAMPLE_W{1'b0}}, w_gain[k]};
        assign w_prod[k] = w_s_ext * w_g_ext;
    end

    // Stage 1: capture products against the gain held before this frame's update.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_v1 <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_prod[i] <= {PROD_W{1'b0}};
            end
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
        end
    end

    // Mix, rescale and either clamp or wrap to the output width.
    always_comb begin
        w_sum = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum = w_sum + SUM_W'(r_prod[i]);
        end
        w_shift = w_sum >>> GAIN_W;
`ifdef AUDIO_MIX_SATURATE_EN
        if ((&w_shift[SUM_W-1:SAMPLE_W-1]) || !(|w_shift[SUM_W-1:SAMPLE_W-1])) begin
            w_res  = w_shift[SAMPLE_W-1:0];
            w_clip = 1'b0;
        end else if (w_shift[SUM_W-1]) begin
            w_res  = {1'b1, {(SAMPLE_W-1){1'b0}}};
            w_clip = 1'b1;
        end else begin
            w_res  = {1'b0, {(SAMPLE_W-1){1'b1}}};
            w_clip = 1'b1;
        end
`else
        w_res  = w_shift[SAMPLE_W-1:0];
        w_clip = 1'b0;
`endif
    end

    // Stage 2: registered mix output and its strobes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_out_sample <= {SAMPLE_W{1'b0}};
            r_clip       <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            r_clip      <= r_v1 & w_clip;
            if (r_v1) begin
                r_out_sample <= w_res;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign clip       = r_clip;

endmodule

// File: tb/tb_audio_fade_mixer.sv
// Directed bench for audio_fade_mixer (SAMPLE_W=16, NUM_CH=2, GAIN_W=4, RAMP_STEP=4).
// Expected values are hand-computed; clamp/wrap expectations follow AUDIO_MIX_SATURATE_EN.
module tb_audio_fade_mixer;

    logic               clk = 1'b0;
    logic               resetn;
    logic [1:0]         ch_enable;
    logic               mute;
    logic               in_valid;
    logic [31:0]        in_sample;
    logic               out_valid;
    logic signed [15:0] out_sample;
    logic [1:0]         ch_active;
    logic               clip;

    int n_checks = 0;
    int n_errors = 0;

    audio_fade_mixer #(
        .SAMPLE_W  (16),
        .NUM_CH    (2),
        .GAIN_W    (4),
        .RAMP_STEP (4)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .ch_enable  (ch_enable),
        .mute       (mute),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .ch_active  (ch_active),
        .clip       (clip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One frame: output is checked two cycles after the strobe, then one idle cycle.
    task automatic frame(input int s0, input int s1, input logic m,
                         input int exp, input int exp_clip, input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = {16'(s1), 16'(s0)};
        mute      = m;
        @(negedge clk);
        in_valid  = 1'b0;
        mute      = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_sample, exp);
        check({tag, "_clip"}, clip, exp_clip);
        @(negedge clk);
    endtask

    int bb_exp [8] = '{0, 80, 240, 480, 800, 960, 1120, 1280};
    int sat_hi, sat_lo, clip_exp;

    initial begin
`ifdef AUDIO_MIX_SATURATE_EN
        sat_hi = 32767;  sat_lo = -32768; clip_exp = 1;
`else
        sat_hi = -5536;  sat_lo = 5536;   clip_exp = 0;
`endif
        resetn = 1'b0; ch_enable = 2'b00; mute = 1'b0; in_valid = 1'b0; in_sample = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sample", out_sample, 0);
        check("rst_clip", clip, 0);
        check("rst_active", ch_active, 0);
        resetn = 1'b1;

        // Fade-in of channel 0 to unity
        ch_enable = 2'b01;
        frame(1000, 0, 1'b0, 0, 0, "fi0");
        check("fi_active", ch_active, 2'b01);
        frame(1000, 0, 1'b0, 250, 0, "fi1");
        frame(1000, 0, 1'b0, 500, 0, "fi2");
        frame(1000, 0, 1'b0, 750, 0, "fi3");
        frame(1000, 0, 1'b0, 1000, 0, "fi4");
        frame(1000, 0, 1'b0, 1000, 0, "fi5");

        // Full fade-out from PLAY
        ch_enable = 2'b00;
        frame(1000, 0, 1'b0, 1000, 0, "fo0");
        frame(1000, 0, 1'b0, 750, 0, "fo1");
        frame(1000, 0, 1'b0, 500, 0, "fo2");
        frame(1000, 0, 1'b0, 250, 0, "fo3");
        check("fo_idle", ch_active, 2'b00);

        // Reversal after two fade-in frames
        ch_enable = 2'b01;
        frame(1000, 0, 1'b0, 0, 0, "rv0");
        frame(1000, 0, 1'b0, 250, 0, "rv1");
        ch_enable = 2'b00;
        frame(1000, 0, 1'b0, 500, 0, "rv2");
        check("rv_active", ch_active, 2'b01);
        frame(1000, 0, 1'b0, 250, 0, "rv3");
        check("rv_idle", ch_active, 2'b00);
        frame(1000, 0, 1'b0, 0, 0, "rv4");

        // Saturation / wrap with both channels at unity
        ch_enable = 2'b11;
        for (int i = 0; i < 4; i++) frame(0, 0, 1'b0, 0, 0, "sat_ramp");
        frame(30000, 30000, 1'b0, sat_hi, clip_exp, "sat_pos");
        frame(-30000, -30000, 1'b0, sat_lo, clip_exp, "sat_neg");
        frame(1000, -500, 1'b0, 500, 0, "mix_small");
        frame(-32768, 0, 1'b0, -32768, 0, "mix_min");

        // Mute: coincident frame uses the old gains, then silence
        frame(1000, 1000, 1'b1, 2000, 0, "mute_frame");
        check("mute_idle", ch_active, 2'b00);
        frame(1000, 1000, 1'b0, 0, 0, "mute_next");
        check("mute_restart", ch_active, 2'b11);
        @(negedge clk); mute = 1'b1;
        @(negedge clk); mute = 1'b0;
        check("mute_novalid", ch_active, 2'b00);
        ch_enable = 2'b00;
        @(negedge clk);

        // Back-to-back frames: each output exactly two cycles after its input
        ch_enable = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                in_valid  = 1'b1;
                in_sample = {16'd7777, 16'(160 * (c + 1))};
            end else begin
                in_valid  = 1'b0;
            end
            if (c >= 2) begin
                check("bb_valid", out_valid, 1);
                check("bb_sample", out_sample, bb_exp[c-2]);
            end else begin
                check("bb_early", out_valid, 0);
            end
        end
        @(negedge clk);
        check("bb_tail", out_valid, 0);

        // Reset mid-fade with frames in flight
        ch_enable = 2'b00;
        @(negedge clk);
        in_valid = 1'b1; in_sample = {16'd0, 16'd1000};
        @(negedge clk);
        in_sample = {16'd0, 16'd2000};
        #2 resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("rst_mid_valid", out_valid, 0);
            check("rst_mid_sample", out_sample, 0);
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_sample", out_sample, 0);
            check("post_rst_clip", clip, 0);
            check("post_rst_active", ch_active, 0);
        end
        ch_enable = 2'b01;
        frame(1000, 0, 1'b0, 0, 0, "resume0");
        check("resume_active", ch_active, 2'b01);
        frame(1000, 0, 1'b0, 250, 0, "resume1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
